or_reduce_pipe: RTL and testbench

Parametrised, pipelined OR (or NOR) reduction of a WIDTH-bit input vector. It is built as a tree of GROUP-input OR nodes with a register after every tree level. A valid bit travels alongside the data, a clock enable stalls the whole pipeline, and a sticky "any-hit" flag latches when a valid result is 1. It is the registered, scalable successor to the fixed-width combinational OR macros, for wide error/interrupt/status aggregation where a flat gate would limit timing.

---
 rtl/or_reduce_pipe_if.sv | 23 ++
 rtl/or_reduce_pipe.sv | 85 ++++++++
 tb/tb_or_reduce_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/or_reduce_pipe_if.sv
// Handshake bundle for or_reduce_pipe: stimulus in, reduced result out.
// The master drives the vector and controls; the slave returns result flags.
interface or_reduce_pipe_if #(
  parameter int WIDTH = 11
);
  logic             CE;
  logic [WIDTH-1:0] A;
  logic             VI;
  logic             CLR;
  logic             Z0;
  logic             VO;
  logic             ZS;

  modport master (
    output CE, A, VI, CLR,
    input  Z0, VO, ZS
  );

  modport slave (
    input  CE, A, VI, CLR,
    output Z0, VO, ZS
  );
endinterface

// File: rtl/or_reduce_pipe.sv
// Pipelined GROUP-ary OR/NOR reduction tree with a valid chain
// and a sticky hit flag; one register after every tree level.
module or_reduce_pipe #(
  parameter int WIDTH = 11,
  parameter int GROUP = 4,
  parameter bit INV   = 1'b0
) (
  input logic             CK,
  input logic             CDN,
  or_reduce_pipe_if.slave bus
);

  function automatic int f_lw(int w, int g, int l);
    int r;
    r = w;
    for (int i = 0; i < l; i++) r = (r + g - 1) / g;
    return r;
  endfunction

  function automatic int f_lat(int w, int g);
    int r;
    int n;
    r = w;
    n = 0;
    do begin
      r = (r + g - 1) / g;
      n++;
    end while (r > 1);
    return n;
  endfunction

  localparam int LAT = f_lat(WIDTH, GROUP);

  logic [WIDTH-1:0] r_lvl [LAT];
  logic [WIDTH-1:0] w_src [LAT];
  logic [WIDTH-1:0] w_nxt [LAT];
  logic [LAT-1:0]   r_v;
  logic             r_zs;
  logic             w_hit;

  always_comb begin
    w_src[0] = bus.A;
    for (int l = 1; l < LAT; l++) w_src[l] = r_lvl[l-1];
  end

  // Bits past a level's live width stay 0, which doubles as group padding.
  always_comb begin
    for (int l = 0; l < LAT; l++) begin
      w_nxt[l] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        if (j < f_lw(WIDTH, GROUP, l))
          w_nxt[l][j/GROUP] = w_nxt[l][j/GROUP] | w_src[l][j];
      end
    end
    w_nxt[LAT-1][0] = w_nxt[LAT-1][0] ^ INV;
  end

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      for (int l = 0; l < LAT; l++) r_lvl[l] <= '0;
      r_v <= '0;
    end else if (bus.CE) begin
      for (int l = 0; l < LAT; l++) r_lvl[l] <= w_nxt[l];
      r_v[0] <= bus.VI;
      for (int l = 1; l < LAT; l++) r_v[l] <= r_v[l-1];
    end
  end

  assign w_hit = r_v[LAT-1] & r_lvl[LAT-1][0];

  // A hit outranks a simultaneous clear so no event is lost.
  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      r_zs <= 1'b0;
    end else if (bus.CE) begin
      if (w_hit)        r_zs <= 1'b1;
      else if (bus.CLR) r_zs <= 1'b0;
    end
  end

  assign bus.Z0 = r_lvl[LAT-1][0];
  assign bus.VO = r_v[LAT-1];
  assign bus.ZS = r_zs;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Bench for or_reduce_pipe: three sizes (11/4, 64/4 NOR, 1/4)
// checked each cycle against a stage-queue model.
module tb_or_reduce_pipe;

  logic clk;
  logic cdn;

  or_reduce_pipe_if #(.WIDTH(11)) b0 ();
  or_reduce_pipe_if #(.WIDTH(64)) b1 ();
  or_reduce_pipe_if #(.WIDTH(1))  b2 ();

  or_reduce_pipe #(.WIDTH(11), .GROUP(4), .INV(1'b0)) u0 (
    .CK(clk), .CDN(cdn), .bus(b0)
  );
  or_reduce_pipe #(.WIDTH(64), .GROUP(4), .INV(1'b1)) u1 (
    .CK(clk), .CDN(cdn), .bus(b1)
  );
  or_reduce_pipe #(.WIDTH(1), .GROUP(4), .INV(1'b0)) u2 (
    .CK(clk), .CDN(cdn), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        ce, vi, clr;
  logic [63:0] a;

  int lat_t [3] = '{2, 3, 1};
  bit inv_t [3] = '{1'b0, 1'b1, 1'b0};

  bit pv [3][4];
  bit pz [3][4];
  bit ov [3];
  bit oz [3];
  bit os [3];

  function automatic bit raw_or(int d);
    case (d)
      0:       return |a[10:0];
      1:       return |a;
      default: return a[0];
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        pv[d][i] = 1'b0;
        pz[d][i] = 1'b0;
      end
      ov[d] = 1'b0;
      oz[d] = 1'b0;
      os[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit sv, sz;
    int l;
    if (!cdn) begin
      model_reset();
      return;
    end
    if (!ce) return;
    for (int d = 0; d < 3; d++) begin
      l = lat_t[d];
      if (ov[d] && oz[d]) os[d] = 1'b1;
      else if (clr)       os[d] = 1'b0;
      sv = (l == 1) ? vi : pv[d][l-2];
      sz = (l == 1) ? raw_or(d) : pz[d][l-2];
      ov[d] = sv;
      oz[d] = sz ^ inv_t[d];
      for (int i = 3; i > 0; i--) begin
        pv[d][i] = pv[d][i-1];
        pz[d][i] = pz[d][i-1];
      end
      pv[d][0] = vi;
      pz[d][0] = raw_or(d);
    end
  endtask

  task automatic chk(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w11.Z0", b0.Z0, oz[0]);
    chk("w11.VO", b0.VO, ov[0]);
    chk("w11.ZS", b0.ZS, os[0]);
    chk("w64.Z0", b1.Z0, oz[1]);
    chk("w64.VO", b1.VO, ov[1]);
    chk("w64.ZS", b1.ZS, os[1]);
    chk("w1.Z0",  b2.Z0, oz[2]);
    chk("w1.VO",  b2.VO, ov[2]);
    chk("w1.ZS",  b2.ZS, os[2]);
  endtask

  task automatic drive(logic c, logic v, logic k, logic [63:0] x);
    ce = c; vi = v; clr = k; a = x;
    b0.CE = c; b0.VI = v; b0.CLR = k; b0.A = x[10:0];
    b1.CE = c; b1.VI = v; b1.CLR = k; b1.A = x;
    b2.CE = c; b2.VI = v; b2.CLR = k; b2.A = x[0:0];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [63:0] rx;
    int          m;
    model_reset();
    cdn = 1'b0;
    drive(1'b1, 1'b1, 1'b0, '1);
    #2;
    check_all();
    step();
    step();

    // release between edges, keep streaming valid all-ones
    cdn = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("w11.first_vo", b0.VO, 1'b1);

    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 1'b1, 1'b0, 64'd1 << k);
      step();
    end
    drive(1'b1, 1'b1, 1'b0, 64'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) step();

    drive(1'b1, 1'b0, 1'b1, 64'd0);
    step();
    step();

    for (int i = 0; i < 12; i++) begin
      drive((i >= 4 && i < 7) ? 1'b0 : 1'b1, 1'b1, 1'b0,
            (i % 2 == 0) ? 64'h1 : 64'h0);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) step();

    drive(1'b1, 1'b0, 1'b1, 64'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 64'h3);
    step();
    drive(1'b1, 1'b1, 1'b0, 64'h4);
    step();
    step();
    drive(1'b1, 1'b0, 1'b1, 64'd0);
    step();
    chk("w11.sticky_hold", b0.ZS, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("w11.sticky_clr", b0.ZS, 1'b0);

    for (int i = 0; i < 300; i++) begin
      m = int'($urandom_range(0, 2));
      if (m == 0)      rx = 64'd0;
      else if (m == 1) rx = 64'd1 << $urandom_range(0, 63);
      else             rx = {$urandom, $urandom};
      drive($urandom_range(0, 5) != 0, 1'($urandom),
            $urandom_range(0, 7) == 0, rx);
      step();
    end

    drive(1'b1, 1'b1, 1'b0, 64'd0);
    step();
    step();
    #3;
    cdn = 1'b0;
    #1;
    model_reset();
    chk("w64.vo_async", b1.VO, 1'b0);
    chk("w11.vo_async", b0.VO, 1'b0);
    check_all();
    #2;
    cdn = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 5; i++) step();
    drive(1'b1, 1'b1, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
